// File: rtl/frame_pkg.sv
// frame_pkg
// Shared definitions for the FIFO-to-frame path: default header bytes,
// the empty-FIFO timeout default, frame overhead, the 8-bit state codes
// (same style as the top-level show_state debug bus) and a helper that
// selects a header byte by index.
package frame_pkg;

  localparam logic [7:0]  HEAD0_DEF = 8'h55;
  localparam logic [7:0]  HEAD1_DEF = 8'hAA;
  localparam int unsigned TMO_DEF   = 1023;

  // Header (6 bytes) plus checksum (1 byte)
  localparam int unsigned FRAME_OVH = 7;

  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_HEAD = 8'h01;
  localparam logic [7:0] ST_PAYL = 8'h02;
  localparam logic [7:0] ST_CSUM = 8'h03;
  localparam logic [7:0] ST_DONE = 8'h04;

  typedef enum logic [7:0] {
    IDLE = ST_IDLE,
    HEAD = ST_HEAD,
    PAYL = ST_PAYL,
    CSUM = ST_CSUM,
    DONE = ST_DONE
  } state_e;

  localparam logic [2:0] HDR_LAST_IDX = 3'd5;

  // Header byte at position idx: HEAD0, HEAD1, kind, info, len hi, len lo
  function automatic logic [7:0] hdrByte(input logic [2:0]  idx,
                                         input logic [7:0]  h0,
                                         input logic [7:0]  h1,
                                         input logic [7:0]  kind,
                                         input logic [7:0]  info,
                                         input logic [11:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = h0;
      3'd1:    b = h1;
      3'd2:    b = kind;
      3'd3:    b = info;
      3'd4:    b = {4'h0, len[11:8]};
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fifod2frame.sv
// fifod2frame
// On a start level (fs) in IDLE, drains data_len bytes from the data FIFO
// and emits one frame over a valid/ready byte interface:
//   HEAD0 HEAD1 dev_kind dev_info {4'h0,len[11:8]} len[7:0] payload.. csum
// csum is the modulo-256 sum of dev_kind through the last payload byte.
// fd pulses once when the frame is finished (or aborted by timeout).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   fs / fd / err       frame start level, done pulse, sticky timeout flag
//   data_len            payload length, latched at start
//   dev_kind, dev_info  device bytes, sampled when their header byte loads
//   fifo_rxd/rxen/empty FIFO read port (data valid the cycle after rxen)
//   tx_rdy/tx_en/tx_d/tx_last  byte stream toward the Ethernet transmitter
module fifod2frame
  import frame_pkg::*;
#(
  parameter logic [7:0]  HEAD0 = HEAD0_DEF,
  parameter logic [7:0]  HEAD1 = HEAD1_DEF,
  parameter int unsigned TMO   = TMO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] data_len,
  input  logic [7:0]  dev_kind,
  input  logic [7:0]  dev_info,
  input  logic [7:0]  fifo_rxd,
  output logic        fifo_rxen,
  input  logic        fifo_empty,
  input  logic        tx_rdy,
  output logic        tx_en,
  output logic [7:0]  tx_d,
  output logic        tx_last
);

  localparam int TW = ($clog2(TMO + 1) > 10) ? $clog2(TMO + 1) : 10;

  state_e      state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [11:0] rem_q, rem_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  csum_q, csum_d;
  logic        outV_q, outV_d;
  logic [7:0]  outD_q, outD_d;
  logic        outLast_q, outLast_d;
  logic        err_q, err_d;

  logic        accept;
  logic        tmoHit;
  logic [7:0]  nextByte;

  // A byte read from the FIFO is presented straight from fifo_rxd in the
  // cycle it arrives (pend_q), so payload runs at one byte per cycle with
  // no gap after the header. If the sink stalls, the byte is parked in
  // outD_q. A new read is only issued when the byte currently on tx_d
  // leaves at this edge, which also keeps a pending byte from ever being
  // overrun.
  assign tx_en   = outV_q | pend_q;
  assign tx_d    = pend_q ? fifo_rxd : outD_q;
  assign tx_last = outLast_q;
  assign fd      = (state_q == DONE);
  assign err     = err_q;
  assign accept  = tx_en & tx_rdy;
  assign tmoHit  = (state_q == PAYL) && (tmo_q == TW'(TMO));

  assign fifo_rxen = ~fifo_empty & (rem_q != 12'd0) & (~tx_en | tx_rdy) & ~tmoHit &
                     ((state_q == PAYL) ||
                      ((state_q == HEAD) && (idx_q == HDR_LAST_IDX)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      tmo_q     <= '0;
      csum_q    <= '0;
      outV_q    <= 1'b0;
      outD_q    <= '0;
      outLast_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      tmo_q     <= tmo_d;
      csum_q    <= csum_d;
      outV_q    <= outV_d;
      outD_q    <= outD_d;
      outLast_q <= outLast_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    pend_d    = 1'b0;
    tmo_d     = tmo_q;
    csum_d    = csum_q;
    outV_d    = outV_q;
    outD_d    = outD_q;
    outLast_d = outLast_q;
    err_d     = err_q;
    nextByte  = 8'h00;

    // Every payload byte is summed exactly once, in its arrival cycle
    if (pend_q) csum_d = csum_q + fifo_rxd;

    if (fifo_rxen) begin
      rem_d  = rem_q - 12'd1;
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fs) begin
          state_d   = HEAD;
          len_d     = data_len;
          rem_d     = data_len;
          idx_d     = 3'd0;
          csum_d    = 8'h00;
          tmo_d     = '0;
          err_d     = 1'b0;
          outV_d    = 1'b1;
          outD_d    = HEAD0;
          outLast_d = 1'b0;
        end
      end
      HEAD: begin
        if (accept) begin
          if (idx_q != HDR_LAST_IDX) begin
            idx_d    = idx_q + 3'd1;
            nextByte = hdrByte(idx_d, HEAD0, HEAD1, dev_kind, dev_info, len_q);
            outD_d   = nextByte;
            if (idx_d >= 3'd2) csum_d = csum_q + nextByte;
          end else begin
            outV_d = 1'b0;
            if (len_q != 12'd0) begin
              state_d = PAYL;
              tmo_d   = '0;
            end else begin
              state_d   = CSUM;
              outV_d    = 1'b1;
              outD_d    = csum_q;
              outLast_d = 1'b1;
            end
          end
        end
      end
      PAYL: begin
        if (pend_q && !tx_rdy) begin
          outV_d = 1'b1;
          outD_d = fifo_rxd;
        end else if (outV_q && tx_rdy) begin
          outV_d = 1'b0;
        end
        if (fifo_rxen) tmo_d = '0;
        else if ((rem_q != 12'd0) && !pend_q && fifo_empty) tmo_d = tmo_q + TW'(1);
        // rem_q==0 means the byte being accepted is the last payload byte;
        // csum_d already includes it when it arrives this cycle
        if ((rem_q == 12'd0) && accept) begin
          state_d   = CSUM;
          outV_d    = 1'b1;
          outD_d    = csum_d;
          outLast_d = 1'b1;
        end else if (tmoHit) begin
          state_d = DONE;
          outV_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d   = DONE;
          outV_d    = 1'b0;
          outLast_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifod2frame.sv
// tb_fifod2frame
// Directed bench for fifod2frame: a small FIFO model feeds the design,
// a negedge monitor records every transferred byte plus handshake
// statistics, and one task per scenario checks the results inline.
module tb_fifod2frame;
  import frame_pkg::*;

  typedef logic [7:0] byteQ_t[$];

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs;
  logic        fd;
  logic        err;
  logic [11:0] data_len;
  logic [7:0]  dev_kind;
  logic [7:0]  dev_info;
  logic [7:0]  fifo_rxd;
  logic        fifo_rxen;
  logic        fifo_empty;
  logic        tx_rdy;
  logic        tx_en;
  logic [7:0]  tx_d;
  logic        tx_last;

  int cmpCount = 0;
  int errCount = 0;

  // FIFO model state
  logic [7:0] fifoMem [0:2047];
  int         wrPtr = 0;
  int         rdPtr = 0;
  logic       forceEmpty = 1'b0;
  logic       flushReq = 1'b0;

  // Monitor state
  int         cyc = 0;
  byteQ_t     capD;
  bit         capL[$];
  int         accCyc[$];
  int         enCount, rxenCount, rdEmptyErr, fdCount, fdCyc, lastCount;
  int         lastCyc, holdErr, stallCount;
  bit         enAtFd;
  bit         stallPrev = 1'b0;
  logic [7:0] stallD;
  logic       stallL;

  fifod2frame #(.TMO(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fs         (fs),
    .fd         (fd),
    .err        (err),
    .data_len   (data_len),
    .dev_kind   (dev_kind),
    .dev_info   (dev_info),
    .fifo_rxd   (fifo_rxd),
    .fifo_rxen  (fifo_rxen),
    .fifo_empty (fifo_empty),
    .tx_rdy     (tx_rdy),
    .tx_en      (tx_en),
    .tx_d       (tx_d),
    .tx_last    (tx_last)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a read, garbage otherwise
  assign fifo_empty = forceEmpty || (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (flushReq) rdPtr <= wrPtr;
    else if (fifo_rxen && (wrPtr != rdPtr)) rdPtr <= rdPtr + 1;
    if (fifo_rxen) fifo_rxd <= fifoMem[rdPtr % 2048];
    else fifo_rxd <= 8'hEE;
  end

  // Monitor sampled at negedge, half a cycle away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_en) enCount++;
    if (fifo_rxen) rxenCount++;
    if (fifo_rxen && fifo_empty) rdEmptyErr++;
    if (fd) begin
      fdCount++;
      fdCyc  = cyc;
      enAtFd = tx_en;
    end
    if (tx_en && tx_rdy) begin
      capD.push_back(tx_d);
      capL.push_back(tx_last);
      accCyc.push_back(cyc);
      if (tx_last) begin
        lastCount++;
        lastCyc = cyc;
      end
    end
    if (stallPrev && (!tx_en || tx_d !== stallD || tx_last !== stallL)) holdErr++;
    if (tx_en && !tx_rdy) stallCount++;
    stallPrev = tx_en && !tx_rdy;
    stallD    = tx_d;
    stallL    = tx_last;
  end

  task automatic clearMon();
    capD.delete();
    capL.delete();
    accCyc.delete();
    enCount = 0; rxenCount = 0; rdEmptyErr = 0; fdCount = 0; fdCyc = 0;
    lastCount = 0; lastCyc = 0; holdErr = 0; stallCount = 0; enAtFd = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr % 2048] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic flushFifo();
    flushReq = 1'b1;
    @(posedge clk); #1;
    flushReq = 1'b0;
  endtask

  task automatic startFrame(input logic [11:0] len, input logic [7:0] kind,
                            input logic [7:0] info);
    data_len = len;
    dev_kind = kind;
    dev_info = info;
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  task automatic waitFd(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(posedge clk); #1;
      if (fdCount != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference frame builder: header, length, payload, modulo-256 checksum
  function automatic byteQ_t buildFrame(input logic [7:0] kind, input logic [7:0] info,
                                        input logic [11:0] len, input byteQ_t pay);
    byteQ_t f;
    logic [7:0] s;
    f = '{HEAD0_DEF, HEAD1_DEF, kind, info, {4'h0, len[11:8]}, len[7:0]};
    s = kind + info + {4'h0, len[11:8]} + len[7:0];
    foreach (pay[i]) begin
      f.push_back(pay[i]);
      s = s + pay[i];
    end
    f.push_back(s);
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmpCount++;
    if ({tx_en, tx_last, fd, err, fifo_rxen} !== 5'b0) begin
      $display("[TB] FAIL reset_flags: got %b need 00000", {tx_en, tx_last, fd, err, fifo_rxen});
      errCount++;
    end
    cmpCount++;
    if (tx_d !== 8'h00) begin
      $display("[TB] FAIL reset_txd: got %h need 00", tx_d);
      errCount++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmpCount++;
    if ({tx_en, fd, fifo_rxen} !== 3'b0) begin
      $display("[TB] FAIL reset_idle: got %b need 000", {tx_en, fd, fifo_rxen});
      errCount++;
    end
  endtask

  task automatic test_normal_frame();
    byteQ_t exp = '{8'h55, 8'hAA, 8'hF5, 8'hC9, 8'h00, 8'h04,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};
    bit ok;
    int nBad;
    for (int i = 1; i <= 4; i++) pushByte(8'(i));
    clearMon();
    startFrame(12'd4, 8'hF5, 8'hC9);
    // The design must have latched the length at start
    data_len = 12'hFFF;
    cmpCount++;
    if (!(tx_en === 1'b1 && tx_d === 8'h55)) begin
      $display("[TB] FAIL normal_start_latency: got en=%b d=%h need en=1 d=55", tx_en, tx_d);
      errCount++;
    end
    waitFd(100, ok);
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL normal_fd_timeout: got no fd need fd within 100 cycles");
      errCount++;
    end
    nBad = 0;
    for (int i = 0; i < exp.size(); i++)
      if (i >= capD.size() || capD[i] !== exp[i]) nBad++;
    cmpCount++;
    if (nBad != 0 || capD.size() != exp.size()) begin
      $display("[TB] FAIL normal_bytes: got %0d bytes (%0d wrong) need 11 bytes 0 wrong", capD.size(), nBad);
      errCount++;
    end
    cmpCount++;
    if (lastCount != 1 || capL.size() != 11 || capL[capL.size()-1] !== 1'b1) begin
      $display("[TB] FAIL normal_last: got %0d tx_last transfers need 1 on the checksum", lastCount);
      errCount++;
    end
    cmpCount++;
    if (fdCount != 1 || fdCyc != lastCyc + 1) begin
      $display("[TB] FAIL normal_fd: got %0d pulses at +%0d need 1 pulse at +1", fdCount, fdCyc - lastCyc);
      errCount++;
    end
    cmpCount++;
    if (enCount != 11 || accCyc.size() != 11 || accCyc[10] - accCyc[0] != 10) begin
      $display("[TB] FAIL normal_throughput: got %0d tx_en cycles need 11 consecutive", enCount);
      errCount++;
    end
    cmpCount++;
    if (rxenCount != 4) begin
      $display("[TB] FAIL normal_rxen: got %0d reads need 4", rxenCount);
      errCount++;
    end
  endtask

  task automatic test_zero_length();
    byteQ_t exp = '{8'h55, 8'hAA, 8'hF5, 8'hC9, 8'h00, 8'h00, 8'hBE};
    bit ok;
    int nBad;
    pushByte(8'h77);
    clearMon();
    startFrame(12'd0, 8'hF5, 8'hC9);
    waitFd(50, ok);
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL zero_fd_timeout: got no fd need fd within 50 cycles");
      errCount++;
    end
    nBad = 0;
    for (int i = 0; i < exp.size(); i++)
      if (i >= capD.size() || capD[i] !== exp[i]) nBad++;
    cmpCount++;
    if (nBad != 0 || capD.size() != exp.size()) begin
      $display("[TB] FAIL zero_bytes: got %0d bytes (%0d wrong) need 7 bytes 0 wrong", capD.size(), nBad);
      errCount++;
    end
    cmpCount++;
    if (rxenCount != 0) begin
      $display("[TB] FAIL zero_rxen: got %0d reads need 0", rxenCount);
      errCount++;
    end
    cmpCount++;
    if (lastCount != 1 || lastCyc != accCyc[accCyc.size()-1]) begin
      $display("[TB] FAIL zero_last: got %0d tx_last transfers need 1 on BE", lastCount);
      errCount++;
    end
    flushFifo();
  endtask

  task automatic test_long_frame();
    bit ok;
    int nBad;
    for (int i = 0; i < 256; i++) pushByte(8'hFF);
    clearMon();
    startFrame(12'h100, 8'hF5, 8'hC9);
    waitFd(600, ok);
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL long_fd_timeout: got no fd need fd within 600 cycles");
      errCount++;
    end
    cmpCount++;
    if (capD.size() != 256 + FRAME_OVH) begin
      $display("[TB] FAIL long_size: got %0d bytes need %0d", capD.size(), 256 + FRAME_OVH);
      errCount++;
    end else begin
      cmpCount++;
      if (capD[4] !== 8'h01 || capD[5] !== 8'h00) begin
        $display("[TB] FAIL long_len: got %h %h need 01 00", capD[4], capD[5]);
        errCount++;
      end
      nBad = 0;
      for (int i = 6; i < 262; i++) if (capD[i] !== 8'hFF) nBad++;
      cmpCount++;
      if (nBad != 0) begin
        $display("[TB] FAIL long_payload: got %0d wrong bytes need 0", nBad);
        errCount++;
      end
      cmpCount++;
      if (capD[262] !== 8'hBF || capL[262] !== 1'b1) begin
        $display("[TB] FAIL long_csum: got %h last=%b need BF last=1", capD[262], capL[262]);
        errCount++;
      end
    end
    cmpCount++;
    if (rxenCount != 256) begin
      $display("[TB] FAIL long_rxen: got %0d reads need 256", rxenCount);
      errCount++;
    end
    cmpCount++;
    if (enCount != 263) begin
      $display("[TB] FAIL long_throughput: got %0d tx_en cycles need 263", enCount);
      errCount++;
    end
  endtask

  task automatic test_back_to_back_stalls();
    logic [31:0] rdyPat   = 32'b1011_0110_1101_0011_1001_1110_0101_1011;
    logic [31:0] emptyPat = 32'b0010_0100_0001_1000_0100_0010_0010_0000;
    byteQ_t pay;
    byteQ_t exp;
    bit ok;
    int nBad;
    for (int i = 0; i < 16; i++) pay.push_back(8'h10 + 8'(i * 11));
    foreach (pay[i]) pushByte(pay[i]);
    exp = buildFrame(8'h3C, 8'h81, 12'd16, pay);
    clearMon();
    startFrame(12'd16, 8'h3C, 8'h81);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tx_rdy     = rdyPat[i % 32];
      forceEmpty = emptyPat[(i * 3) % 32];
      @(posedge clk); #1;
      if (fdCount != 0) begin
        ok = 1'b1;
        break;
      end
    end
    tx_rdy = 1'b1;
    forceEmpty = 1'b0;
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL stall_fd_timeout: got no fd need fd within 400 cycles");
      errCount++;
    end
    nBad = 0;
    for (int i = 0; i < exp.size(); i++)
      if (i >= capD.size() || capD[i] !== exp[i]) nBad++;
    cmpCount++;
    if (nBad != 0 || capD.size() != exp.size()) begin
      $display("[TB] FAIL stall_bytes: got %0d bytes (%0d wrong) need %0d bytes 0 wrong",
               capD.size(), nBad, exp.size());
      errCount++;
    end
    cmpCount++;
    if (holdErr != 0 || stallCount == 0) begin
      $display("[TB] FAIL stall_hold: got %0d hold violations in %0d stalls need 0 in >0", holdErr, stallCount);
      errCount++;
    end
    cmpCount++;
    if (rdEmptyErr != 0) begin
      $display("[TB] FAIL stall_read_empty: got %0d reads while empty need 0", rdEmptyErr);
      errCount++;
    end
    cmpCount++;
    if (lastCount != 1 || rxenCount != 16) begin
      $display("[TB] FAIL stall_counts: got last=%0d reads=%0d need last=1 reads=16", lastCount, rxenCount);
      errCount++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int gap;
    pushByte(8'hA1); pushByte(8'hA2); pushByte(8'hA3);
    clearMon();
    startFrame(12'd8, 8'hF5, 8'hC9);
    waitFd(TMO + 100, ok);
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL tmo_fd_timeout: got no fd need fd within %0d cycles", TMO + 100);
      errCount++;
    end
    cmpCount++;
    if (err !== 1'b1) begin
      $display("[TB] FAIL tmo_err: got %b need 1", err);
      errCount++;
    end
    cmpCount++;
    if (lastCount != 0 || enAtFd) begin
      $display("[TB] FAIL tmo_last: got last=%0d en_at_fd=%b need 0 and 0", lastCount, enAtFd);
      errCount++;
    end
    cmpCount++;
    if (capD.size() != 9 || capD[8] !== 8'hA3) begin
      $display("[TB] FAIL tmo_partial: got %0d bytes need 9 ending in A3", capD.size());
      errCount++;
    end else begin
      gap = fdCyc - accCyc[8];
      cmpCount++;
      if (gap < TMO || gap > TMO + 3) begin
        $display("[TB] FAIL tmo_delay: got %0d cycles need %0d..%0d", gap, TMO, TMO + 3);
        errCount++;
      end
    end
    // A new start clears the sticky error
    clearMon();
    startFrame(12'd0, 8'hF5, 8'hC9);
    cmpCount++;
    if (err !== 1'b0) begin
      $display("[TB] FAIL tmo_err_clear: got %b need 0", err);
      errCount++;
    end
    waitFd(50, ok);
    cmpCount++;
    if (!ok || capD.size() != 7 || capD[6] !== 8'hBE) begin
      $display("[TB] FAIL tmo_next_frame: got %0d bytes need 7 ending in BE", capD.size());
      errCount++;
    end
  endtask

  task automatic test_reset_mid_payload();
    byteQ_t exp = '{8'h55, 8'hAA, 8'hF5, 8'hC9, 8'h00, 8'h04,
                    8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};
    bit ok;
    int nBad;
    flushFifo();
    for (int i = 1; i <= 8; i++) pushByte(8'h30 + 8'(i));
    clearMon();
    startFrame(12'd8, 8'hF5, 8'hC9);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (capD.size() >= 10) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmpCount++;
    if (!ok) begin
      $display("[TB] FAIL rstmid_reach: got %0d bytes need 10 before reset", capD.size());
      errCount++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmpCount++;
    if ({tx_en, tx_last, fd, err, fifo_rxen} !== 5'b0 || tx_d !== 8'h00) begin
      $display("[TB] FAIL rstmid_outputs: got %b d=%h need 00000 d=00",
               {tx_en, tx_last, fd, err, fifo_rxen}, tx_d);
      errCount++;
    end
    repeat (5) @(posedge clk);
    #1;
    cmpCount++;
    if (fdCount != 0) begin
      $display("[TB] FAIL rstmid_no_fd: got %0d fd pulses need 0", fdCount);
      errCount++;
    end
    flushFifo();
    for (int i = 1; i <= 4; i++) pushByte(8'(i));
    clearMon();
    startFrame(12'd4, 8'hF5, 8'hC9);
    waitFd(100, ok);
    nBad = 0;
    for (int i = 0; i < exp.size(); i++)
      if (i >= capD.size() || capD[i] !== exp[i]) nBad++;
    cmpCount++;
    if (!ok || nBad != 0 || capD.size() != exp.size() || lastCount != 1) begin
      $display("[TB] FAIL rstmid_fresh_frame: got %0d bytes (%0d wrong) need 11 bytes 0 wrong", capD.size(), nBad);
      errCount++;
    end
  endtask

  initial begin
    fs = 1'b0;
    data_len = 12'd0;
    dev_kind = 8'h00;
    dev_info = 8'h00;
    tx_rdy = 1'b1;
    fifo_rxd = 8'h00;
    clearMon();
    test_reset();
    test_normal_frame();
    test_zero_length();
    test_long_frame();
    test_back_to_back_stalls();
    test_timeout();
    test_reset_mid_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
